// File: rtl/nios2_c_sysid_checker_pkg.sv
// Shared definitions for the system-ID checker: FSM state encoding, bus word
// addresses and the default expected ID/timestamp words.
package nios2_c_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WT_ID,
    RD_TS,
    WT_TS,
    DONE
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd74565;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1403436289;

endpackage

// File: rtl/nios2_c_sysid_checker_if.sv
// Avalon-MM read-only bus between the system-ID checker (master) and the
// system-ID slave.
interface nios2_c_sysid_checker_if;

  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );

endinterface

// File: rtl/nios2_c_sysid_checker.sv
// Reads the system-ID and timestamp words over Avalon-MM and compares them with
// build-time constants. Optional per-read abort: define SYSID_CHECKER_TIMEOUT_EN.
module nios2_c_sysid_checker
  import nios2_c_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  nios2_c_sysid_checker_if.master        avm,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic                           id_ok,
  output logic                           ts_ok,
  output logic                           timeout,
  output logic [31:0]                    id_value,
  output logic [31:0]                    ts_value
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..65535");
  end

  state_e      state_q, state_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

`ifdef SYSID_CHECKER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] timer_q, timer_d;
  logic        in_read;
  logic        got_resp;
`endif

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    // avm_read is a registered decode of state, so being in RD_* means the
    // command is on the bus and !waitrequest is acceptance.
    case (state_q)
      IDLE: begin
        if (start) begin
          pass_d     = 1'b0;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          timeout_d  = 1'b0;
          id_value_d = '0;
          ts_value_d = '0;
          state_d    = RD_ID;
        end
      end
      RD_ID, WT_ID: begin
        if (state_q == WT_ID || !avm.avm_waitrequest) begin
          if (avm.avm_readdatavalid) begin
            id_value_d = avm.avm_readdata;
            id_ok_d    = (avm.avm_readdata == EXPECTED_ID);
            state_d    = RD_TS;
          end else begin
            state_d    = WT_ID;
          end
        end
      end
      RD_TS, WT_TS: begin
        if (state_q == WT_TS || !avm.avm_waitrequest) begin
          if (avm.avm_readdatavalid) begin
            ts_value_d = avm.avm_readdata;
            ts_ok_d    = (avm.avm_readdata == EXPECTED_TIMESTAMP);
            state_d    = DONE;
          end else begin
            state_d    = WT_TS;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef SYSID_CHECKER_TIMEOUT_EN
    in_read  = (state_q inside {RD_ID, WT_ID, RD_TS, WT_TS});
    got_resp = ((state_q inside {RD_ID, WT_ID}) && state_d == RD_TS) ||
               ((state_q inside {RD_TS, WT_TS}) && state_d == DONE);
    if (in_read && !got_resp && timer_q >= TimeoutLast) begin
      timeout_d = 1'b1;
      state_d   = DONE;
    end

    // The counter spans command and response phase of one read together.
    if ((state_d inside {RD_ID, RD_TS}) && state_d != state_q) begin
      timer_d = '0;
    end else if (state_d inside {RD_ID, WT_ID, RD_TS, WT_TS}) begin
      timer_d = timer_q + 16'd1;
    end else begin
      timer_d = '0;
    end
`endif

    if (state_d == DONE && state_q != DONE) begin
      pass_d = id_ok_d & ts_ok_d & ~timeout_d;
    end

    busy_d        = (state_d inside {RD_ID, WT_ID, RD_TS, WT_TS});
    done_d        = (state_d == DONE);
    avm_read_d    = (state_d inside {RD_ID, RD_TS});
    avm_address_d = (state_d inside {RD_TS, WT_TS}) ? ADDR_TS : ADDR_ID;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      avm_read_q    <= 1'b0;
      avm_address_q <= ADDR_ID;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_q     <= 1'b0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
      timer_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_q     <= timeout_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
`ifdef SYSID_CHECKER_TIMEOUT_EN
      timer_q       <= timer_d;
`endif
    end
  end

  assign avm.avm_read    = avm_read_q;
  assign avm.avm_address = avm_address_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign timeout         = timeout_q;
  assign id_value        = id_value_q;
  assign ts_value        = ts_value_q;

endmodule

// File: tb/tb_nios2_c_sysid_checker.sv
// Directed bench for nios2_c_sysid_checker with a configurable Avalon slave
// model; the timeout scenario runs only when SYSID_CHECKER_TIMEOUT_EN is defined.
module tb_nios2_c_sysid_checker;
  import nios2_c_sysid_pkg::DEFAULT_EXPECTED_ID;
  import nios2_c_sysid_pkg::DEFAULT_EXPECTED_TIMESTAMP;

  logic        clock;
  logic        reset;
  logic        start;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  nios2_c_sysid_checker_if bus ();

  nios2_c_sysid_checker #(
    .EXPECTED_ID        (DEFAULT_EXPECTED_ID),
    .EXPECTED_TIMESTAMP (DEFAULT_EXPECTED_TIMESTAMP),
`ifdef SYSID_CHECKER_TIMEOUT_EN
    .TIMEOUT_CYCLES     (8)
`else
    .TIMEOUT_CYCLES     (255)
`endif
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .avm      (bus.master),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .id_ok    (id_ok),
    .ts_ok    (ts_ok),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          wait_cfg   = 0;
  int          lat_cfg    = 0;
  bit          respond_en = 1'b1;
  logic [31:0] id_data    = DEFAULT_EXPECTED_ID;
  logic [31:0] ts_data    = DEFAULT_EXPECTED_TIMESTAMP;
  bit          stray_valid = 1'b0;
  logic [31:0] stray_data  = 32'h0;

  int done_count  = 0;
  int addr1_count = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Slave model: stalls each command wait_cfg cycles, then answers lat_cfg
  // cycles after acceptance (0 = same cycle). Drives on the falling edge.
  initial begin
    int  stall_cnt;
    bit  pend;
    int  pend_left;
    logic pend_addr;
    stall_cnt = 0; pend = 1'b0; pend_left = 0; pend_addr = 1'b0;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdata      = 32'h0;
    bus.avm_readdatavalid = 1'b0;
    forever begin
      @(negedge clock);
      bus.avm_waitrequest   = 1'b0;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = 32'h0;
      if (pend) begin
        pend_left--;
        if (pend_left == 0) begin
          pend = 1'b0;
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata      = pend_addr ? ts_data : id_data;
        end
      end
      if (stray_valid) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = stray_data;
      end
      if (!bus.avm_read) begin
        stall_cnt = 0;
      end else if (!pend) begin
        if (stall_cnt < wait_cfg) begin
          bus.avm_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          stall_cnt = 0;
          if (respond_en) begin
            if (lat_cfg == 0) begin
              bus.avm_readdatavalid = 1'b1;
              bus.avm_readdata      = bus.avm_address ? ts_data : id_data;
            end else begin
              pend      = 1'b1;
              pend_left = lat_cfg;
              pend_addr = bus.avm_address;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (done === 1'b1) done_count++;
      if (bus.avm_read === 1'b1 && bus.avm_address === 1'b1) addr1_count++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic configure(input int w, input int l, input bit r, input logic [31:0] idw);
    wait_cfg   = w;
    lat_cfg    = l;
    respond_en = r;
    id_data    = idw;
    ts_data    = DEFAULT_EXPECTED_TIMESTAMP;
  endtask

  // Leaves the bench in the first cycle after the edge that sampled start.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 1;
    while (done !== 1'b1 && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus.avm_read, bus.avm_address, busy, done, pass, id_ok, ts_ok, timeout} !== 8'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b required 00000000",
               {bus.avm_read, bus.avm_address, busy, done, pass, id_ok, ts_ok, timeout});
    end
    n_checks++;
    if ({id_value, ts_value} !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got %h/%h required 0/0", id_value, ts_value);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait();
    int cycles;
    configure(0, 0, 1'b1, DEFAULT_EXPECTED_ID);
    pulse_start();
    n_checks++;
    if ({busy, bus.avm_read, bus.avm_address} !== 3'b110) begin
      n_fail++;
      $display("[TB] FAIL zw_rd_id: busy/read/addr got %b required 110", {busy, bus.avm_read, bus.avm_address});
    end
    wait_done(20, cycles);
    n_checks++;
    if (done !== 1'b1 || cycles != 3) begin
      n_fail++;
      $display("[TB] FAIL zw_latency: got done=%b after %0d required done=1 after 3", done, cycles);
    end
    n_checks++;
    if ({pass, id_ok, ts_ok, timeout, busy} !== 5'b11100) begin
      n_fail++;
      $display("[TB] FAIL zw_flags: pass/id_ok/ts_ok/timeout/busy got %b required 11100",
               {pass, id_ok, ts_ok, timeout, busy});
    end
    n_checks++;
    if (id_value !== 32'd74565 || ts_value !== 32'd1403436289) begin
      n_fail++;
      $display("[TB] FAIL zw_values: got %0d/%0d required 74565/1403436289", id_value, ts_value);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || pass !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL zw_after: done/pass got %b%b required 01", done, pass);
    end
    tick();
  endtask

  task automatic test_id_mismatch();
    int cycles;
    configure(0, 0, 1'b1, 32'd74566);
    pulse_start();
    n_checks++;
    if (pass !== 1'b0 || id_value !== 32'h0 || id_ok !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mm_clear: pass/id_ok/id_value got %b/%b/%0d required 0/0/0", pass, id_ok, id_value);
    end
    wait_done(20, cycles);
    n_checks++;
    if (done !== 1'b1 || cycles != 3) begin
      n_fail++;
      $display("[TB] FAIL mm_latency: got done=%b after %0d required done=1 after 3", done, cycles);
    end
    n_checks++;
    if ({pass, id_ok, ts_ok} !== 3'b001 || id_value !== 32'd74566) begin
      n_fail++;
      $display("[TB] FAIL mm_result: pass/id_ok/ts_ok got %b id_value %0d required 001 74566",
               {pass, id_ok, ts_ok}, id_value);
    end
    repeat (2) tick();
  endtask

  task automatic test_wait_states();
    int   cycles, stalls, unstable;
    logic prev_stall, prev_addr;
    configure(4, 2, 1'b1, DEFAULT_EXPECTED_ID);
    stalls = 0; unstable = 0; prev_stall = 1'b0; prev_addr = 1'b0;
    pulse_start();
    cycles = 1;
    while (cycles < 40) begin
      if (bus.avm_waitrequest === 1'b1) begin
        stalls++;
        if (bus.avm_read !== 1'b1) unstable++;
        if (prev_stall && bus.avm_address !== prev_addr) unstable++;
      end
      prev_stall = bus.avm_waitrequest;
      prev_addr  = bus.avm_address;
      if (done === 1'b1) break;
      tick();
      cycles++;
    end
    n_checks++;
    if (done !== 1'b1 || cycles != 15) begin
      n_fail++;
      $display("[TB] FAIL ws_latency: got done=%b after %0d required done=1 after 15", done, cycles);
    end
    n_checks++;
    if (stalls != 8 || unstable != 0) begin
      n_fail++;
      $display("[TB] FAIL ws_stall: stalls %0d unstable %0d required 8 and 0", stalls, unstable);
    end
    n_checks++;
    if (pass !== 1'b1 || ts_value !== 32'd1403436289) begin
      n_fail++;
      $display("[TB] FAIL ws_result: pass %b ts_value %0d required 1 1403436289", pass, ts_value);
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    int cycles, base;
    configure(0, 0, 1'b1, DEFAULT_EXPECTED_ID);
    base = done_count;
    pulse_start();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_done: got %b required 1", done);
    end
    repeat (6) tick();
    cycles = done_count - base;
    n_checks++;
    if (cycles != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: done pulses %0d busy %b required 1 and 0", cycles, busy);
    end
    stray_data  = 32'hDEADBEEF;
    stray_valid = 1'b1;
    tick();
    stray_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (id_value !== 32'd74565 || ts_value !== 32'd1403436289 || pass !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stray_valid: id/ts/pass got %0d/%0d/%b required 74565/1403436289/1",
               id_value, ts_value, pass);
    end
    n_checks++;
    if (done_count - base != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stray_done: done pulses %0d busy %b required 1 and 0", done_count - base, busy);
    end
  endtask

  task automatic test_reset_midop();
    int cycles, base;
    configure(0, 3, 1'b1, DEFAULT_EXPECTED_ID);
    base = done_count;
    pulse_start();
    cycles = 0;
    while (!(busy === 1'b1 && bus.avm_address === 1'b1 && bus.avm_read === 1'b0) && cycles < 30) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (cycles >= 30) begin
      n_fail++;
      $display("[TB] FAIL rst_reach_wt_ts: got no WT_TS in %0d cycles required WT_TS", cycles);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({bus.avm_read, bus.avm_address, busy, done, pass, id_ok, ts_ok, timeout} !== 8'b0 ||
        {id_value, ts_value} !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL rst_midop: flags %b values %h/%h required all zero",
               {bus.avm_read, bus.avm_address, busy, done, pass, id_ok, ts_ok, timeout}, id_value, ts_value);
    end
    repeat (6) tick();
    n_checks++;
    if ({busy, pass, id_ok, ts_ok} !== 4'b0 || {id_value, ts_value} !== 64'h0 || done_count != base) begin
      n_fail++;
      $display("[TB] FAIL rst_late_resp: flags %b values %h/%h done pulses %0d required zeros and 0",
               {busy, pass, id_ok, ts_ok}, id_value, ts_value, done_count - base);
    end
  endtask

`ifdef SYSID_CHECKER_TIMEOUT_EN
  task automatic test_timeout();
    int cycles, base_a1;
    configure(0, 0, 1'b0, DEFAULT_EXPECTED_ID);
    base_a1 = addr1_count;
    pulse_start();
    wait_done(40, cycles);
    n_checks++;
    if (done !== 1'b1 || cycles < 8 || cycles > 10) begin
      n_fail++;
      $display("[TB] FAIL to_latency: got done=%b after %0d required done=1 after 8..10", done, cycles);
    end
    n_checks++;
    if ({timeout, pass, id_ok, bus.avm_read} !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL to_flags: timeout/pass/id_ok/read got %b required 1000",
               {timeout, pass, id_ok, bus.avm_read});
    end
    repeat (4) tick();
    n_checks++;
    if (addr1_count != base_a1 || timeout !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL to_no_ts_read: addr1 cycles %0d timeout %b required 0 and 1",
               addr1_count - base_a1, timeout);
    end
    respond_en = 1'b1;
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_zero_wait();
    test_id_mismatch();
    test_wait_states();
    test_back_to_back();
    test_reset_midop();
`ifdef SYSID_CHECKER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nios2_c_sysid_checker.md
# nios2_c_sysid_checker

Avalon-MM read master that interrogates the system-ID slave at boot or on demand. It reads the ID word (address 0) and the timestamp word (address 1), then compares both against expected values fixed at build time. It reports pass/fail and the captured words. It sits beside the Nios II core on the same interconnect and gates software start-up on a matching hardware image.

## Interface
Parameters:
- EXPECTED_ID, 32'd74565: expected word at address 0.
- EXPECTED_TIMESTAMP, 32'd1403436289: expected word at address 1.
- TIMEOUT_CYCLES, 255: maximum cycles per read before abort (only used with the timeout feature); legal range 1..65535.

Ports:
- clock  in  1: single clock; all logic rising-edge.
- reset  in  1: synchronous, active-high reset.
- start  in  1: one-cycle request to run a check.
- avm_address  out  1: word address (0 = ID, 1 = timestamp).
- avm_read  out  1: read request.
- avm_waitrequest  in  1: slave stall; command accepted when avm_read & !avm_waitrequest.
- avm_readdata  in  32: read data, sampled when avm_readdatavalid=1.
- avm_readdatavalid  in  1: read response strobe.
- busy  out  1: high from the cycle after an accepted start until done.
- done  out  1: one-cycle pulse at check completion.
- pass  out  1: id_ok & ts_ok & !timeout, held until the next start.
- id_ok, ts_ok  out  1 each: individual compare results, held until the next start.
- timeout  out  1: check aborted, held until the next start.
- id_value, ts_value  out  32 each: captured words, held until the next start.

## Operation
- States: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, DONE.
- IDLE: start=1 clears id_ok, ts_ok, timeout, pass, id_value and ts_value, then moves to RD_ID.
- RD_ID: avm_read=1, avm_address=0, held stable while avm_waitrequest=1.
  - Accepted with readdatavalid in the same cycle: capture the data and go to RD_TS.
  - Accepted without readdatavalid: go to WT_ID.
- WT_ID: avm_read=0; readdatavalid captures id_value and id_ok=(data==EXPECTED_ID), then moves to RD_TS.
- RD_TS and WT_TS: same rules as RD_ID/WT_ID with address 1, capturing ts_value and ts_ok.
- DONE: done=1 and pass updated for one cycle, then IDLE.
- Only one read is outstanding at any time.
- Ignored events:
  - start while not in IDLE.
  - readdatavalid in IDLE, RD_* before acceptance, or DONE (stale response).
- Reset mid-operation: the next edge forces IDLE, and any response still in flight is ignored.

## Timing
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, pass=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0.
- All outputs are registered.
- Zero-wait slave with same-cycle valid:
  - start sampled at edge N.
  - RD_ID during cycle N+1.
  - RD_TS during N+2.
  - done=1 during N+3.
  - Total latency is 3 cycles.
- Each wait-request cycle and each response-latency cycle adds one cycle.
- busy=1 in RD_ID..WT_TS, busy=0 in DONE.

## Configuration
- Macro: SYSID_CHECKER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to each RD_* state and increments in RD_*/WT_*.
  - On reaching TIMEOUT_CYCLES without the expected response, drop avm_read, set timeout=1, and go to DONE; pass=0.
  - A timeout ends the check: the timestamp is not read after an ID timeout.
- Undefined: no counter; the FSM waits indefinitely; timeout is tied to 0.

## Structure
- Shared package nios2_c_sysid_pkg holds:
  - The state enum typedef.
  - ADDR_ID=1'b0 and ADDR_TS=1'b1.
  - Default EXPECTED_ID and EXPECTED_TIMESTAMP constants, also used by the bench.
- No sub-module; the FSM and counter live in one module.

## Test plan
- Zero-wait slave returning 74565 / 1403436289, start pulse -> done at start+3, pass=1, id_ok=1, ts_ok=1, id_value=74565.
- Slave ID returns 74566 -> done, id_ok=0, ts_ok=1, pass=0, id_value=74566.
- waitrequest held 4 cycles on each read plus 2-cycle response latency -> address/read stable while stalled, done at start+15, pass=1.
- start pulsed again while busy, and stray readdatavalid in IDLE -> ignored; exactly one done, and captured values are unchanged.
- Reset asserted in WT_TS, then the response arrives -> outputs hold their reset values and no done pulse occurs.
- With SYSID_CHECKER_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never responds to the ID read -> done with timeout=1, pass=0, avm_read=0; address 1 is never issued.
